// File: rtl/instruction_fetch_controller_pkg.sv
// Shared definitions for the instruction fetch controller.
// Holds the fetch FSM state type, the PC step, the default reset PC and the
// instruction word width.
package instruction_fetch_controller_pkg;

  // Fetch sequencer states.
  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StReq   = 2'd1,
    StHold  = 2'd2,
    StDrain = 2'd3
  } fetch_state_e;

  localparam int unsigned InstrW         = 32;
  localparam logic [31:0] PcIncr         = 32'd4;
  localparam logic [31:0] DefaultResetPc = 32'h0000_0000;

endpackage

// File: rtl/pc_update_unit.sv
// Program counter register with its next-PC selection.
// Ports:
//   clk_i     rising-edge clock
//   rst_i     asynchronous active-high reset, loads ResetPc
//   incr_i    advance the PC by one instruction word
//   load_i    load target_i (word aligned); wins over incr_i
//   target_i  byte target address, bits [1:0] are cleared
//   pc_o      current byte PC
module pc_update_unit
  import instruction_fetch_controller_pkg::*;
#(
  parameter logic [31:0] ResetPc = DefaultResetPc
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        incr_i,
  input  logic        load_i,
  input  logic [31:0] target_i,
  output logic [31:0] pc_o
);

  logic [31:0] pc_q, pc_d;

  always_comb begin
    pc_d = pc_q;
    if (load_i) begin
      pc_d = target_i & ~32'd3;
    end else if (incr_i) begin
      pc_d = pc_q + PcIncr;  // wraps mod 2^32
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      pc_q <= ResetPc;
    end else begin
      pc_q <= pc_d;
    end
  end

  assign pc_o = pc_q;

endmodule

// File: rtl/instruction_fetch_controller.sv
// Instruction fetch sequencer: owns the PC, runs a req/ready handshake to the
// instruction memory and presents fetched instructions to decode, honouring
// stall and branch/jump redirect (including squashing an in-flight fetch).
// Ports:
//   CLK, RESET                clock / asynchronous active-high reset
//   stall                     decode not accepting; hold current instruction
//   redirect, redirect_target taken branch/jump and its byte target
//   imem_req, imem_addr       fetch request and word address to memory
//   imem_ready, imem_rdata    memory response
//   instruction_out, pc_out   fetched instruction and its byte PC
//   instr_valid               instruction_out/pc_out valid
//   flush                     one-cycle pulse when a redirect is accepted
module instruction_fetch_controller
  import instruction_fetch_controller_pkg::*;
#(
  parameter int unsigned ADDR_W   = 8,
  parameter logic [31:0] RESET_PC = DefaultResetPc
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic              stall,
  input  logic              redirect,
  input  logic [31:0]       redirect_target,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic              imem_ready,
  input  logic [31:0]       imem_rdata,
  output logic [InstrW-1:0] instruction_out,
  output logic [31:0]       pc_out,
  output logic              instr_valid,
  output logic              flush
);

  fetch_state_e      state_q, state_d;
  logic [31:0]       pc;
  logic              pc_incr, pc_load;
  logic [ADDR_W-1:0] pc_addr;
  // Address of a request squashed by redirect; re-presented until it completes.
  logic [ADDR_W-1:0] drain_addr_q, drain_addr_d;
  logic [InstrW-1:0] instr_q, instr_d;
  logic [31:0]       pc_out_q, pc_out_d;
  logic              valid_q, valid_d;
  logic              flush_q, flush_d;

  pc_update_unit #(
    .ResetPc (RESET_PC)
  ) u_pc_update_unit (
    .clk_i    (CLK),
    .rst_i    (RESET),
    .incr_i   (pc_incr),
    .load_i   (pc_load),
    .target_i (redirect_target),
    .pc_o     (pc)
  );

  assign pc_addr = pc[ADDR_W+1:2];

  always_comb begin
    state_d      = state_q;
    drain_addr_d = drain_addr_q;
    instr_d      = instr_q;
    pc_out_d     = pc_out_q;
    valid_d      = valid_q;
    flush_d      = 1'b0;
    pc_incr      = 1'b0;
    pc_load      = 1'b0;
    imem_req     = 1'b0;
    imem_addr    = pc_addr;

    unique case (state_q)
      StIdle: begin
        // Redirect is ignored here.
        state_d = StReq;
      end
      StReq: begin
        imem_req = 1'b1;
        if (redirect) begin
          pc_load = 1'b1;
          valid_d = 1'b0;
          flush_d = 1'b1;
          if (!imem_ready) begin
            // Memory still owes us a response for the old address.
            drain_addr_d = pc_addr;
            state_d      = StDrain;
          end
        end else if (imem_ready) begin
          instr_d  = imem_rdata;
          pc_out_d = pc;
          valid_d  = 1'b1;
          pc_incr  = 1'b1;
          state_d  = stall ? StHold : StReq;
        end else if (!stall) begin
          valid_d = 1'b0;
        end
      end
      StHold: begin
        if (redirect) begin
          pc_load = 1'b1;
          valid_d = 1'b0;
          flush_d = 1'b1;
          state_d = StReq;
        end else if (!stall) begin
          // Consumed; refetch starts next cycle, leaving one bubble.
          valid_d = 1'b0;
          state_d = StReq;
        end
      end
      StDrain: begin
        imem_req  = 1'b1;
        imem_addr = drain_addr_q;
        if (redirect) begin
          pc_load = 1'b1;
          valid_d = 1'b0;
          flush_d = 1'b1;
        end else if (imem_ready) begin
          // Returned data belongs to the squashed path; drop it.
          state_d = StReq;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_q      <= StIdle;
      drain_addr_q <= '0;
      instr_q      <= '0;
      pc_out_q     <= '0;
      valid_q      <= 1'b0;
      flush_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      drain_addr_q <= drain_addr_d;
      instr_q      <= instr_d;
      pc_out_q     <= pc_out_d;
      valid_q      <= valid_d;
      flush_q      <= flush_d;
    end
  end

  assign instruction_out = instr_q;
  assign pc_out          = pc_out_q;
  assign instr_valid     = valid_q;
  assign flush           = flush_q;

endmodule

// File: tb/tb_instruction_fetch_controller.sv
// Self-checking bench for instruction_fetch_controller: directed scenarios
// followed by randomized stall/redirect/ready traffic, all compared each cycle
// against a behavioural model of the fetch rules.
module tb_instruction_fetch_controller;

  localparam int unsigned AddrW    = 8;
  localparam int unsigned MemWords = 1 << AddrW;

  logic             CLK = 1'b0;
  logic             RESET = 1'b1;
  logic             stall = 1'b0;
  logic             redirect = 1'b0;
  logic [31:0]      redirect_target = '0;
  logic             imem_req;
  logic [AddrW-1:0] imem_addr;
  logic             imem_ready = 1'b0;
  logic [31:0]      imem_rdata;
  logic [31:0]      instruction_out;
  logic [31:0]      pc_out;
  logic             instr_valid;
  logic             flush;

  logic [31:0] mem [MemWords];

  assign imem_rdata = mem[imem_addr];

  always #5 CLK = ~CLK;

  instruction_fetch_controller #(
    .ADDR_W   (AddrW),
    .RESET_PC (32'h0000_0000)
  ) dut (
    .CLK             (CLK),
    .RESET           (RESET),
    .stall           (stall),
    .redirect        (redirect),
    .redirect_target (redirect_target),
    .imem_req        (imem_req),
    .imem_addr       (imem_addr),
    .imem_ready      (imem_ready),
    .imem_rdata      (imem_rdata),
    .instruction_out (instruction_out),
    .pc_out          (pc_out),
    .instr_valid     (instr_valid),
    .flush           (flush)
  );

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h @%0t", tag, got, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  typedef enum int {MStart, MFetch, MHeld, MDrain} mphase_e;

  mphase_e          m_phase;
  logic [31:0]      m_pc, m_instr, m_pcout;
  logic             m_valid, m_flush;
  logic [AddrW-1:0] m_old_word;

  function automatic logic [AddrW-1:0] word_of(input logic [31:0] byte_pc);
    return byte_pc[AddrW+1:2];
  endfunction

  function automatic logic m_req();
    return (m_phase == MFetch) || (m_phase == MDrain);
  endfunction

  function automatic logic [AddrW-1:0] m_addr();
    return (m_phase == MDrain) ? m_old_word : word_of(m_pc);
  endfunction

  task automatic model_reset();
    m_phase    = MStart;
    m_pc       = 32'h0;
    m_instr    = '0;
    m_pcout    = '0;
    m_valid    = 1'b0;
    m_flush    = 1'b0;
    m_old_word = '0;
  endtask

  task automatic model_step(input logic s, input logic r, input logic [31:0] t, input logic rd);
    m_flush = 1'b0;
    if (m_phase == MStart) begin
      m_phase = MFetch;
    end else if (r) begin
      // Taken branch wins over stall and memory response.
      if (m_phase == MFetch && !rd) begin
        m_old_word = word_of(m_pc);
        m_phase    = MDrain;
      end else if (m_phase != MDrain) begin
        m_phase = MFetch;
      end
      m_pc    = {t[31:2], 2'b00};
      m_valid = 1'b0;
      m_flush = 1'b1;
    end else if (m_phase == MFetch) begin
      if (rd) begin
        m_instr = mem[word_of(m_pc)];
        m_pcout = m_pc;
        m_valid = 1'b1;
        m_pc    = m_pc + 32'd4;
        if (s) m_phase = MHeld;
      end else if (!s) begin
        m_valid = 1'b0;
      end
    end else if (m_phase == MHeld) begin
      if (!s) begin
        m_valid = 1'b0;
        m_phase = MFetch;
      end
    end else if (m_phase == MDrain) begin
      if (rd) m_phase = MFetch;
    end
  endtask

  task automatic compare_model();
    check_eq("instruction_out", instruction_out, m_instr);
    check_eq("pc_out", pc_out, m_pcout);
    check_eq("instr_valid", 32'(instr_valid), 32'(m_valid));
    check_eq("flush", 32'(flush), 32'(m_flush));
    check_eq("imem_req", 32'(imem_req), 32'(m_req()));
    if (m_req()) check_eq("imem_addr", 32'(imem_addr), 32'(m_addr()));
  endtask

  // Called at a falling edge: check, drive inputs for the next rising edge, advance.
  task automatic cycle(input logic s, input logic r, input logic [31:0] t, input logic rd);
    logic rdg;
    rdg = rd & m_req();
    compare_model();
    stall           = s;
    redirect        = r;
    redirect_target = t;
    imem_ready      = rdg;
    model_step(s, r, t, rdg);
    @(negedge CLK);
  endtask

  task automatic do_reset();
    RESET      = 1'b1;
    stall      = 1'b0;
    redirect   = 1'b0;
    imem_ready = 1'b0;
    model_reset();
    @(negedge CLK);
    @(negedge CLK);
    RESET = 1'b0;
  endtask

  task automatic run_to_fetch_of_pc8();
    for (int i = 0; i < 10; i++) begin
      if (m_phase == MFetch && m_pc == 32'h8) break;
      cycle(1'b0, 1'b0, 32'h0, 1'b1);
    end
  endtask

  logic [31:0] fib [6];

  initial begin
    logic        found;
    int unsigned wait_cnt;
    logic        rd;

    fib = '{32'd1, 32'd1, 32'd2, 32'd3, 32'd5, 32'd8};
    for (int i = 0; i < int'(MemWords); i++) mem[i] = $urandom;
    for (int i = 0; i < 6; i++) mem[i] = fib[i];

    // Ready tied high: Fibonacci words stream out one per cycle.
    do_reset();
    check_eq("rst_valid", 32'(instr_valid), 32'h0);
    check_eq("rst_req", 32'(imem_req), 32'h0);
    for (int i = 0; i < 8; i++) begin
      if (i == 1) check_eq("t1_first_bubble", 32'(instr_valid), 32'h0);
      if (i >= 2) begin
        check_eq("t1_instr", instruction_out, fib[i-2]);
        check_eq("t1_pc", pc_out, 32'(4 * (i - 2)));
        check_eq("t1_valid", 32'(instr_valid), 32'h1);
      end
      cycle(1'b0, 1'b0, 32'h0, 1'b1);
    end

    // Ready arrives on the third cycle of every request.
    do_reset();
    wait_cnt = 0;
    for (int i = 0; i < 30; i++) begin
      rd = m_req() && (wait_cnt == 2);
      wait_cnt = (rd || !m_req()) ? 0 : wait_cnt + 1;
      cycle(1'b0, 1'b0, 32'h0, rd);
    end

    // Stall while (2,0x8) is captured and held.
    do_reset();
    run_to_fetch_of_pc8();
    for (int j = 0; j < 4; j++) begin
      cycle(1'b1, 1'b0, 32'h0, 1'b1);
      check_eq("t3_hold_instr", instruction_out, 32'd2);
      check_eq("t3_hold_pc", pc_out, 32'h8);
      check_eq("t3_hold_req", 32'(imem_req), 32'h0);
    end
    cycle(1'b0, 1'b0, 32'h0, 1'b1);
    check_eq("t3_bubble", 32'(instr_valid), 32'h0);
    cycle(1'b0, 1'b0, 32'h0, 1'b1);
    check_eq("t3_next_instr", instruction_out, 32'd3);
    check_eq("t3_next_pc", pc_out, 32'hC);

    // Redirect while a request is outstanding: drain then refetch at 0x14.
    do_reset();
    for (int i = 0; i < 3; i++) cycle(1'b0, 1'b0, 32'h0, 1'b1);
    cycle(1'b0, 1'b1, 32'h14, 1'b0);
    check_eq("t4_flush", 32'(flush), 32'h1);
    check_eq("t4_valid", 32'(instr_valid), 32'h0);
    cycle(1'b0, 1'b0, 32'h0, 1'b0);
    found = 1'b0;
    for (int i = 0; i < 10 && !found; i++) begin
      cycle(1'b0, 1'b0, 32'h0, 1'b1);
      found = instr_valid;
    end
    check_eq("t4_found", 32'(found), 32'h1);
    check_eq("t4_instr", instruction_out, 32'd8);
    check_eq("t4_pc", pc_out, 32'h14);

    // Redirect to an unaligned target while held.
    do_reset();
    run_to_fetch_of_pc8();
    cycle(1'b1, 1'b0, 32'h0, 1'b1);
    cycle(1'b1, 1'b1, 32'h17, 1'b1);
    check_eq("t5_flush", 32'(flush), 32'h1);
    check_eq("t5_valid", 32'(instr_valid), 32'h0);
    cycle(1'b0, 1'b0, 32'h0, 1'b1);
    check_eq("t5_instr", instruction_out, 32'd8);
    check_eq("t5_pc", pc_out, 32'h14);

    // Asynchronous reset between clock edges.
    do_reset();
    for (int i = 0; i < 3; i++) cycle(1'b0, 1'b0, 32'h0, 1'b1);
    #2;
    RESET = 1'b1;
    #1;
    check_eq("t6_req", 32'(imem_req), 32'h0);
    check_eq("t6_valid", 32'(instr_valid), 32'h0);
    check_eq("t6_flush", 32'(flush), 32'h0);
    check_eq("t6_instr", instruction_out, 32'h0);
    model_reset();
    stall      = 1'b0;
    redirect   = 1'b0;
    imem_ready = 1'b0;
    @(negedge CLK);
    RESET = 1'b0;
    cycle(1'b0, 1'b0, 32'h0, 1'b1);
    cycle(1'b0, 1'b0, 32'h0, 1'b1);
    check_eq("t6_restart_instr", instruction_out, 32'd1);
    check_eq("t6_restart_pc", pc_out, 32'h0);
    check_eq("t6_restart_valid", 32'(instr_valid), 32'h1);

    // Randomized traffic, including targets near the 32-bit wrap.
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      logic [31:0] t;
      t = ($urandom_range(0, 7) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(0, 15)))
                                      : 32'($urandom_range(0, 2047));
      cycle($urandom_range(0, 3) == 0, $urandom_range(0, 9) == 0, t,
            $urandom_range(0, 2) != 0);
    end
    compare_model();

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
